mux64_4_rr_sel: RTL and testbench

MUX64_4_RR_SEL -- requirements
Module: mux64_4_rr_sel

---
 rtl/mux64_4_pkg.sv | 19 +
 rtl/mux64_4_2.sv | 27 ++
 rtl/rr_pick4.sv | 39 +++
 rtl/mux64_4_rr_sel.sv | 126 ++++++++++++
 tb/tb_mux64_4_rr_sel.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mux64_4_pkg.sv
// ---------------------------------------------------------------------------
// mux64_4_pkg
// Shared constants and types for the 4-channel round-robin select block that
// steers the mux64_4_2 data mux.
//   NUM_CH  : number of requesting channels
//   SEL_W   : width of the mux select / channel index
//   state_e : arbiter FSM states
// ---------------------------------------------------------------------------
package mux64_4_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

endpackage : mux64_4_pkg

// File: rtl/mux64_4_2.sv
// ---------------------------------------------------------------------------
// mux64_4_2
// Plain 64-bit 4:1 data mux; the select x comes from mux64_4_rr_sel.
//   y0..y3 [63:0] in  : channel data
//   x      [1:0]  in  : select
//   z      [63:0] out : selected data
// ---------------------------------------------------------------------------
module mux64_4_2 (
    input  logic [63:0] y0,
    input  logic [63:0] y1,
    input  logic [63:0] y2,
    input  logic [63:0] y3,
    input  logic [1:0]  x,
    output logic [63:0] z
);

    always_comb begin
        z = y0;
        case (x)
            2'd0:    z = y0;
            2'd1:    z = y1;
            2'd2:    z = y2;
            default: z = y3;
        endcase
    end

endmodule : mux64_4_2

// File: rtl/rr_pick4.sv
// ---------------------------------------------------------------------------
// rr_pick4
// Combinational rotating-priority search over four request bits.
// The search starts at channel ptr and proceeds ptr+1, ptr+2, ptr+3 (mod 4);
// the first set bit wins.
//   req   [3:0] in  : request vector
//   ptr   [1:0] in  : highest-priority channel for this search
//   found       out : at least one request bit is set
//   idx   [1:0] out : winning channel (equals ptr when nothing is found)
// ---------------------------------------------------------------------------
module rr_pick4
    import mux64_4_pkg::*;
(
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    output logic              found,
    output logic [SEL_W-1:0]  idx
);

    logic [2*NUM_CH-1:0] req_dbl;
    logic [NUM_CH-1:0]   req_rot;
    logic [SEL_W-1:0]    offset;

    always_comb begin
        found   = |req;
        // Rotate so that channel ptr lands at bit 0; the lowest set bit of the
        // rotated vector is then the distance from ptr to the winner.
        req_dbl = {req, req};
        req_rot = req_dbl[ptr +: NUM_CH];
        offset  = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                offset = SEL_W'(i);
            end
        end
        idx = ptr + offset;
    end

endmodule : rr_pick4

// File: rtl/mux64_4_rr_sel.sv
// ---------------------------------------------------------------------------
// mux64_4_rr_sel
// Round-robin owner selection for a 4-channel, 64-bit data mux (mux64_4_2).
// A channel that wins arbitration owns the mux until its final transfer,
// withdrawal of its request, or reset.
//   LOCK_EN        param : 1 = hold ownership until a last-flagged transfer,
//                          0 = hand over after every transfer
//   clk            in    : clock, rising edge
//   rst            in    : asynchronous active-high reset
//   req       [3:0] in   : per-channel request (data present on y<i>)
//   last      [3:0] in   : per-channel last-beat flag (only owner's is used)
//   out_ready      in    : downstream accepts z this cycle
//   x         [1:0] out  : registered mux select
//   gnt       [3:0] out  : one-hot grant, zero when idle
//   out_valid      out   : z carries valid data this cycle
//   busy           out   : a channel currently owns the mux
//
// Handshake: a beat moves when out_valid && out_ready are both high at a
// rising clock edge. out_valid may rise or fall without waiting for
// out_ready (it simply follows the owner's request); out_ready never
// feeds out_valid.
// ---------------------------------------------------------------------------
module mux64_4_rr_sel
    import mux64_4_pkg::*;
#(
    parameter bit LOCK_EN = 1'b1
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] req,
    input  logic [NUM_CH-1:0] last,
    input  logic              out_ready,
    output logic [SEL_W-1:0]  x,
    output logic [NUM_CH-1:0] gnt,
    output logic              out_valid,
    output logic              busy
);

    state_e           state_q, state_d;
    logic [SEL_W-1:0] ptr_q,   ptr_d;
    logic [SEL_W-1:0] x_q,     x_d;

    logic             owner_req;
    logic             xfer;
    logic             final_xfer;
    logic [SEL_W-1:0] x_next;
    logic [SEL_W-1:0] search_ptr;
    logic             pick_found;
    logic [SEL_W-1:0] pick_idx;

    // In GRANT the only arbitration is on a final transfer, where the new
    // pointer is x+1; searching from there leaves the current owner last.
    // In IDLE the search starts from the stored pointer.
    always_comb begin
        x_next     = x_q + SEL_W'(1);
        search_ptr = (state_q == ST_GRANT) ? x_next : ptr_q;
    end

    rr_pick4 u_pick (
        .req   (req),
        .ptr   (search_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        owner_req  = req[x_q];
        xfer       = (state_q == ST_GRANT) && owner_req && out_ready;
        final_xfer = xfer && (last[x_q] || !LOCK_EN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            x_q     <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            x_q     <= x_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        x_d     = x_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    x_d     = pick_idx;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (!owner_req) begin
                    // Owner withdrew mid-packet: release and rotate.
                    ptr_d   = x_next;
                    state_d = ST_IDLE;
                end else if (final_xfer) begin
                    ptr_d = x_next;
                    if (pick_found) begin
                        // Back-to-back handover, no idle bubble.
                        x_d = pick_idx;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs depend only on registered state, except out_valid which is
    // qualified combinationally by the owner's live request.
    always_comb begin
        x         = x_q;
        busy      = (state_q == ST_GRANT);
        gnt       = busy ? (NUM_CH'(1) << x_q) : '0;
        out_valid = busy && req[x_q];
    end

endmodule : mux64_4_rr_sel

// File: tb/tb_mux64_4_rr_sel.sv
module tb_mux64_4_rr_sel;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [3:0]  last;
    logic        out_ready;
    logic [63:0] y0, y1, y2, y3;
    logic [63:0] z;

    logic [1:0]  x0, x1;
    logic [3:0]  gnt0, gnt1;
    logic        ov0, ov1;
    logic        busy0, busy1;

    int n_pass  = 0;
    int n_total = 0;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- DUTs ----------------
    mux64_4_rr_sel u_dut0 (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .last      (last),
        .out_ready (out_ready),
        .x         (x0),
        .gnt       (gnt0),
        .out_valid (ov0),
        .busy      (busy0)
    );

    mux64_4_rr_sel #(.LOCK_EN(1'b0)) u_dut1 (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .last      (last),
        .out_ready (out_ready),
        .x         (x1),
        .gnt       (gnt1),
        .out_valid (ov1),
        .busy      (busy1)
    );

    mux64_4_2 u_mux (
        .y0 (y0),
        .y1 (y1),
        .y2 (y2),
        .y3 (y3),
        .x  (x0),
        .z  (z)
    );

    // ---------------- reference model ----------------
    // own_m = owning channel or -1 when idle; index 0 is LOCK_EN=1, 1 is LOCK_EN=0.
    int own_m[2];
    int ptr_m[2];
    int x_m[2];
    bit lock_m[2] = '{1'b1, 1'b0};

    function automatic int pick(logic [3:0] r, int p);
        for (int k = 0; k < 4; k++) begin
            if (r[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            own_m[k] = -1;
            ptr_m[k] = 0;
            x_m[k]   = 0;
        end
    endtask

    task automatic model_clock();
        int w;
        if (rst) begin
            model_reset();
            return;
        end
        for (int k = 0; k < 2; k++) begin
            if (own_m[k] < 0) begin
                w = pick(req, ptr_m[k]);
                if (w >= 0) begin
                    own_m[k] = w;
                    x_m[k]   = w;
                end
            end else if (!req[own_m[k]]) begin
                ptr_m[k] = (own_m[k] + 1) % 4;
                own_m[k] = -1;
            end else if (out_ready && (last[own_m[k]] || !lock_m[k])) begin
                ptr_m[k] = (own_m[k] + 1) % 4;
                w = pick(req, ptr_m[k]);
                own_m[k] = w;
                if (w >= 0) x_m[k] = w;
            end
        end
    endtask

    // ---------------- scoreboard ----------------
    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    endtask

    function automatic logic [63:0] sel_y(int s);
        case (s)
            0:       return y0;
            1:       return y1;
            2:       return y2;
            default: return y3;
        endcase
    endfunction

    task automatic check_all(string ph);
        logic [3:0] eg;
        logic       ev;
        for (int k = 0; k < 2; k++) begin
            eg = (own_m[k] >= 0) ? (4'b0001 << own_m[k]) : 4'b0000;
            ev = (own_m[k] >= 0) ? req[own_m[k]] : 1'b0;
            if (k == 0) begin
                chk({ph, "_x0"},    64'(x0),    64'(x_m[0]));
                chk({ph, "_gnt0"},  64'(gnt0),  64'(eg));
                chk({ph, "_busy0"}, 64'(busy0), 64'(own_m[0] >= 0));
                chk({ph, "_ov0"},   64'(ov0),   64'(ev));
            end else begin
                chk({ph, "_x1"},    64'(x1),    64'(x_m[1]));
                chk({ph, "_gnt1"},  64'(gnt1),  64'(eg));
                chk({ph, "_busy1"}, 64'(busy1), 64'(own_m[1] >= 0));
                chk({ph, "_ov1"},   64'(ov1),   64'(ev));
            end
        end
        chk({ph, "_z"}, z, sel_y(x_m[0]));
    endtask

    // ---------------- driver ----------------
    // Called at a falling edge: drives one cycle of inputs, checks before and
    // after the following rising edge.
    task automatic step(logic [3:0] r, logic [3:0] l, logic rd, logic rs);
        rst       = rs;
        req       = r;
        last      = l;
        out_ready = rd;
        y0 = {$urandom, $urandom};
        y1 = {$urandom, $urandom};
        y2 = {$urandom, $urandom};
        y3 = {$urandom, $urandom};
        if (rs) model_reset();
        #1;
        check_all("pre");
        @(posedge clk);
        model_clock();
        @(negedge clk);
        check_all("post");
    endtask

    task automatic do_reset();
        step(4'b0000, 4'b0000, 1'b0, 1'b1);
        rst = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1; req = '0; last = '0; out_ready = 1'b0;
        y0 = '0; y1 = '0; y2 = '0; y3 = '0;
        model_reset();
        @(negedge clk);
        #1;
        check_all("reset");
        chk("reset_gnt", 64'(gnt0), 64'd0);

        // Single request from reset.
        do_reset();
        step(4'b0100, 4'b0000, 1'b0, 1'b0);
        chk("r28_x",   64'(x0),    64'd2);
        chk("r28_gnt", 64'(gnt0),  64'h4);
        chk("r28_bsy", 64'(busy0), 64'd1);
        chk("r28_ov",  64'(ov0),   64'd1);

        // All requesting, every beat last: strict rotation, no bubbles.
        do_reset();
        step(4'b1111, 4'b1111, 1'b1, 1'b0);
        chk("r29_x_a", 64'(x0), 64'd0);
        step(4'b1111, 4'b1111, 1'b1, 1'b0);
        chk("r29_x_b", 64'(x0), 64'd1);
        step(4'b1111, 4'b1111, 1'b1, 1'b0);
        chk("r29_x_c", 64'(x0), 64'd2);
        step(4'b1111, 4'b1111, 1'b1, 1'b0);
        chk("r29_x_d", 64'(x0), 64'd3);
        step(4'b1111, 4'b1111, 1'b1, 1'b0);
        chk("r29_x_e", 64'(x0), 64'd0);
        chk("r29_bsy", 64'(busy0), 64'd1);

        // Locked multi-beat packet on channel 1.
        do_reset();
        step(4'b0010, 4'b0000, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(4'b1111, 4'b0000, 1'b1, 1'b0);
            chk("r30_hold", 64'(x0), 64'd1);
        end
        step(4'b1111, 4'b0010, 1'b1, 1'b0);
        chk("r30_next", 64'(x0), 64'd2);

        // Backpressure on channel 3, then wrap of the pointer.
        do_reset();
        step(4'b1000, 4'b0000, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(4'b1001, 4'b0000, 1'b0, 1'b0);
            chk("r31_x",   64'(x0),   64'd3);
            chk("r31_gnt", 64'(gnt0), 64'h8);
            chk("r31_ov",  64'(ov0),  64'd1);
        end
        step(4'b1001, 4'b1000, 1'b1, 1'b0);
        chk("r31_wrap", 64'(x0), 64'd0);

        // Withdrawal by owner 2, then arbitration from pointer 3.
        do_reset();
        step(4'b0100, 4'b0000, 1'b0, 1'b0);
        step(4'b0000, 4'b0000, 1'b1, 1'b0);
        chk("r32_gnt", 64'(gnt0),  64'd0);
        chk("r32_bsy", 64'(busy0), 64'd0);
        step(4'b0101, 4'b0000, 1'b0, 1'b0);
        chk("r32_x", 64'(x0), 64'd0);

        // Asynchronous reset mid-packet, mux path under reset.
        do_reset();
        step(4'b0010, 4'b0000, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk("r33_gnt", 64'(gnt0),  64'd0);
        chk("r33_bsy", 64'(busy0), 64'd0);
        chk("r33_x",   64'(x0),    64'd0);
        chk("r33_ov",  64'(ov0),   64'd0);
        for (int i = 0; i < 64; i++) begin
            logic [63:0] pat;
            pat = 64'd1 << i;
            y0  = pat;
            y1  = {$urandom, $urandom};
            y2  = ~pat;
            y3  = {$urandom, $urandom};
            #1;
            chk("r33_mux", z, pat);
        end
        @(negedge clk);
        step(4'b1010, 4'b0000, 1'b0, 1'b0);
        chk("r33_first", 64'(x0), 64'd1);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            step(4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 49) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_mux64_4_rr_sel
